// File: rtl/sub_bytes_seq.sv
// Forward AES SubBytes engine: substitutes a 128-bit state BPC bytes per cycle through
// the FIPS-197 forward S-box behind valid/ready handshakes on both sides.
module sub_bytes_seq #(
  parameter int unsigned BPC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state,
  output logic         busy
);

  localparam int unsigned NumGroups = 16 / BPC;
  localparam int unsigned CntW      = (NumGroups > 1) ? $clog2(NumGroups) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumGroups - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Entry i of the forward S-box sits at index i (leftmost byte is S(00)).
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
    $error("sub_bytes_seq: BPC must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [0:127]    work_q, work_d;
  logic [0:127]    out_q, out_d;
  logic [0:127]    subst;
  int unsigned     base;

  // Working register with the current byte group replaced by its S-box image.
  always_comb begin
    subst = work_q;
    base  = 32'(cnt_q) * BPC;
    for (int unsigned j = 0; j < BPC; j++) begin
      subst[8*(base+j) +: 8] = SBOX[work_q[8*(base+j) +: 8]];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    out_d   = out_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d  = in_state;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        work_d = subst;
        if (cnt_q == LastCnt) begin
          out_d   = subst;
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      work_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StBusy);
  assign out_valid = (state_q == StDone);
  assign out_state = out_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Scoreboard bench for sub_bytes_seq: acceptances push expected results computed from a
// GF(2^8) S-box model; a negedge monitor checks latency, value and hold behaviour.
module tb_sub_bytes_seq;

  localparam int unsigned Bpc = 4;
  localparam int unsigned Lat = 16 / Bpc;
  localparam logic [0:127] FipsIn  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [0:127] FipsOut = 128'hd42711aee0bf98f1b8b45de51e415230;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [0:127] in_state = '0;
  logic         in_ready, out_valid, busy;
  logic [0:127] out_state;

  logic         aux_valid = 1'b0;
  logic         aux_ready = 1'b1;
  logic [0:127] aux_state = '0;
  logic         ir1, ov1, bz1, ir16, ov16, bz16;
  logic [0:127] os1, os16;

  always #5 clk = ~clk;

  sub_bytes_seq #(.BPC(Bpc)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .busy(busy)
  );

  sub_bytes_seq #(.BPC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(aux_valid), .in_ready(ir1),
    .in_state(aux_state), .out_valid(ov1), .out_ready(aux_ready),
    .out_state(os1), .busy(bz1)
  );

  sub_bytes_seq #(.BPC(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(aux_valid), .in_ready(ir16),
    .in_state(aux_state), .out_valid(ov16), .out_ready(aux_ready),
    .out_state(os16), .busy(bz16)
  );

  typedef struct {
    logic [0:127] data;
    int unsigned  acc;
  } exp_t;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  int unsigned  cyc = 0;
  logic [7:0]   sb_ref [256];
  logic         prev_ov = 1'b0;
  logic [0:127] last_out = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S(b) = affine(b^-1) in GF(2^8) mod x^8+x^4+x^3+x+1, with 0 mapping to 0 before the affine.
  task automatic build_ref();
    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
      sb_ref[b] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [0:127] model(input logic [0:127] s);
    logic [0:127] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sb_ref[s[8*i +: 8]];
    return r;
  endfunction

  // Monitor: acceptance pushes, completion pops; result checked every DONE cycle for hold.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) exp_q.push_back('{model(in_state), cyc + 1});
    if (out_valid && !prev_ov) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", 128'(out_valid), 128'(0));
      else chk("latency", 128'(cyc - exp_q[0].acc), 128'(Lat));
    end
    if (out_valid) begin
      chk("in_ready_in_done", 128'(in_ready), 128'(0));
      if (exp_q.size() > 0) begin
        chk("out_state", out_state, exp_q[0].data);
        if (out_ready) begin
          last_out <= out_state;
          void'(exp_q.pop_front());
        end
      end
    end
    prev_ov <= out_valid;
  end

  task automatic send(input logic [0:127] s);
    int t = 0;
    in_state = s;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) begin
      chk("send_timeout", 128'(0), 128'(1));
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(in_ready && !out_valid) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) chk("idle_timeout", 128'(0), 128'(1));
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!out_valid) chk("valid_timeout", 128'(0), 128'(1));
  endtask

  function automatic logic [0:127] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [0:127] s, bp_x, res1, res16;
    int lat1, lat16;
    build_ref();

    #12;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_state", out_state, 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All-zero state: every byte becomes 63.
    send('0);
    chk("busy_after_accept", 128'(busy), 128'(1));
    wait_idle();
    chk("zero_vector", last_out, {16{8'h63}});
    chk("idle_in_ready", 128'(in_ready), 128'(1));

    send(FipsIn);
    wait_idle();
    chk("fips_vector", last_out, FipsOut);

    // Backpressure: result held, new input ignored, one transfer on release.
    out_ready = 1'b0;
    bp_x = rand_state();
    send(bp_x);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_state = rand_state();
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_out_valid", 128'(out_valid), 128'(1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 128'(in_ready), 128'(1));
    chk("bp_release_out_valid", 128'(out_valid), 128'(0));
    chk("retain_after_handshake", out_state, model(bp_x));

    // Every byte value 00..FF across 16 states.
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) s[8*i +: 8] = 8'(16 * k + i);
      send(s);
      wait_idle();
    end
    s = rand_state();
    s[0:7] = 8'h53;
    s[120:127] = 8'hff;
    send(s);
    wait_idle();
    chk("s_53", 128'(last_out[0:7]), 128'(8'hed));
    chk("s_ff", 128'(last_out[120:127]), 128'(8'h16));

    // Reset during the second BUSY cycle.
    send(rand_state());
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_out_state", out_state, 128'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (Lat + 4) @(posedge clk);
    #1;
    chk("midrst_no_valid", 128'(out_valid), 128'(0));
    send(FipsIn);
    wait_idle();
    chk("fips_after_reset", last_out, FipsOut);

    // Random states with random backpressure.
    for (int n = 0; n < 20; n++) begin
      send(rand_state());
      out_ready = 1'b0;
      repeat ($urandom_range(0, 4)) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_idle();
    end

    // Latency and result at BPC=1 and BPC=16.
    chk("aux_idle", 128'({ir1, ir16}), 128'(2'b11));
    aux_state = FipsIn;
    aux_valid = 1'b1;
    @(posedge clk); #1;
    aux_valid = 1'b0;
    lat1 = -1;
    lat16 = -1;
    res1 = '0;
    res16 = '0;
    for (int t = 0; t < 40; t++) begin
      if (ov1 && lat1 < 0) begin
        lat1 = t;
        res1 = os1;
      end
      if (ov16 && lat16 < 0) begin
        lat16 = t;
        res16 = os16;
      end
      @(posedge clk); #1;
    end
    chk("bpc1_latency", 128'(lat1), 128'(16));
    chk("bpc16_latency", 128'(lat16), 128'(1));
    chk("bpc1_fips", res1, FipsOut);
    chk("bpc16_fips", res16, FipsOut);

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
